// File: rtl/spi_reg_slave.sv
// SPI mode-0 register slave: 64 x 8-bit register file shared with a local port.
// Define SPI_SLV_BURST_EN to let a transaction walk through consecutive addresses.
module spi_reg_slave #(
  parameter logic [5:0] ID_ADDR  = 6'h37,
  parameter logic [7:0] ID_VALUE = 8'h92
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_sck,
  input  logic       spi_mosi,
  input  logic       spi_cs_n,
  output logic       spi_miso,
  input  logic [5:0] loc_adr,
  input  logic       loc_we,
  input  logic [7:0] loc_dat_i,
  output logic [7:0] loc_dat_o,
  output logic       wr_evt,
  output logic [5:0] wr_adr,
  output logic       busy
);

`ifdef SPI_SLV_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t      state, state_nxt;
  logic [2:0]  sck_q, cs_q;
  logic [1:0]  mosi_q;
  logic        sck_rise, sck_fall, cs_fall, cs_high, mosi_s;
  logic [2:0]  bit_cnt;
  logic [6:0]  shift_in;  // the 8th bit is taken straight from mosi_s
  logic [7:0]  in_byte;
  logic [7:0]  shift_out;
  logic        rw, data_done;
  logic [5:0]  addr;
  logic [7:0]  regs [64];
  logic        addr_last, data_last, byte_live, spi_commit, miso_drive;

  function automatic logic [7:0] rd(input logic [5:0] a);
    return (a == ID_ADDR) ? ID_VALUE : regs[a];
  endfunction

  // CS stages reset low so a CS already held low at reset release is not seen as a falling edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sck_q  <= '0;
      cs_q   <= '0;
      mosi_q <= '0;
    end else begin
      sck_q  <= {sck_q[1:0], spi_sck};
      cs_q   <= {cs_q[1:0], spi_cs_n};
      mosi_q <= {mosi_q[0], spi_mosi};
    end
  end

  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign sck_fall = ~sck_q[1] & sck_q[2];
  assign cs_fall  = ~cs_q[1] & cs_q[2];
  assign cs_high  = cs_q[1];
  assign mosi_s   = mosi_q[1];
  assign in_byte  = {shift_in, mosi_s};

  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (cs_fall) state_nxt = ADDR;
      ADDR: if (cs_high) state_nxt = IDLE;
            else if (addr_last) state_nxt = DATA;
      DATA: if (cs_high) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: every combinational output gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    busy       = 1'b0;
    addr_last  = 1'b0;
    data_last  = 1'b0;
    miso_drive = 1'b0;
    unique case (state)
      IDLE: ;
      ADDR: begin
        busy      = 1'b1;
        addr_last = sck_rise && !cs_high && (bit_cnt == 3'd7);
      end
      DATA: begin
        busy       = 1'b1;
        data_last  = sck_rise && !cs_high && (bit_cnt == 3'd7);
        miso_drive = sck_fall && !cs_high;
      end
      default: ;
    endcase
  end

  assign byte_live  = BURST || !data_done;
  assign spi_commit = data_last && !rw && byte_live && (addr != ID_ADDR);

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt   <= '0;
      shift_in  <= '0;
      shift_out <= '0;
      rw        <= 1'b0;
      addr      <= '0;
      data_done <= 1'b0;
      spi_miso  <= 1'b0;
      wr_evt    <= 1'b0;
      wr_adr    <= '0;
      loc_dat_o <= '0;
    end else begin
      wr_evt    <= spi_commit;
      loc_dat_o <= rd(loc_adr);
      if (spi_commit) wr_adr <= addr;
      if (cs_high || state == IDLE) begin
        bit_cnt   <= '0;
        data_done <= 1'b0;
        spi_miso  <= 1'b0;
      end else begin
        if (sck_rise) begin
          shift_in <= in_byte[6:0];
          bit_cnt  <= bit_cnt + 3'd1;
        end
        if (addr_last) begin
          rw   <= in_byte[7];
          addr <= in_byte[6:1];
          if (in_byte[7]) shift_out <= rd(in_byte[6:1]);
        end
        if (data_last) begin
          data_done <= 1'b1;
          if (BURST) begin
            addr <= addr + 6'd1;
            if (rw) shift_out <= rd(addr + 6'd1);
          end
        end
        if (miso_drive) begin
          spi_miso  <= rw && byte_live && shift_out[7];
          shift_out <= {shift_out[6:0], 1'b0};
        end
      end
    end
  end

  // NOTE: the register file is reset explicitly because its reset contents
  // are architecturally visible; ID_ADDR is never written and is muxed on read.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) regs[i] <= 8'h00;
    end else begin
      if (loc_we && loc_adr != ID_ADDR) regs[loc_adr] <= loc_dat_i;
      // Issued last so an SPI write wins a same-address collision.
      if (spi_commit) regs[addr] <= in_byte;
    end
  end

endmodule

// File: tb/tb_spi_reg_slave.sv
// Directed bench for spi_reg_slave: pin-level SPI master model plus local-port accesses.
module tb_spi_reg_slave;

  logic       clk = 1'b0;
  logic       reset;
  logic       spi_sck, spi_mosi, spi_cs_n, spi_miso;
  logic [5:0] loc_adr;
  logic       loc_we;
  logic [7:0] loc_dat_i, loc_dat_o;
  logic       wr_evt;
  logic [5:0] wr_adr;
  logic       busy;

  int tests  = 0;
  int failed = 0;
  int evt_cnt;

  spi_reg_slave dut (
    .clk       (clk),
    .reset     (reset),
    .spi_sck   (spi_sck),
    .spi_mosi  (spi_mosi),
    .spi_cs_n  (spi_cs_n),
    .spi_miso  (spi_miso),
    .loc_adr   (loc_adr),
    .loc_we    (loc_we),
    .loc_dat_i (loc_dat_i),
    .loc_dat_o (loc_dat_o),
    .wr_evt    (wr_evt),
    .wr_adr    (wr_adr),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset)       evt_cnt <= 0;
    else if (wr_evt) evt_cnt <= evt_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // SCK period 80 ns = 8 clk periods; data changes while SCK is low.
  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - n; i--) begin
      spi_mosi = tx[i];
      #40;
      spi_sck = 1'b1;
      rx[i]   = spi_miso;
      #40;
      spi_sck = 1'b0;
    end
  endtask

  task automatic spi_begin();
    spi_cs_n = 1'b0;
    #80;
  endtask

  task automatic spi_end();
    #40;
    spi_cs_n = 1'b1;
    #80;
  endtask

  task automatic spi_xfer2(input logic [7:0] b0, input logic [7:0] b1,
                           output logic [7:0] r0, output logic [7:0] r1);
    spi_begin();
    spi_bits(b0, 8, r0);
    spi_bits(b1, 8, r1);
    spi_end();
  endtask

  task automatic loc_write(input logic [5:0] a, input logic [7:0] d);
    @(negedge clk);
    loc_adr = a; loc_dat_i = d; loc_we = 1'b1;
    @(negedge clk);
    loc_we = 1'b0;
  endtask

  task automatic loc_read(input logic [5:0] a, output logic [7:0] d);
    @(negedge clk);
    loc_adr = a;
    @(negedge clk);
    d = loc_dat_o;
  endtask

  initial begin
    logic [7:0] r0, r1, d;
    int         e0;
    bit         seen;

    reset = 1'b1; spi_sck = 1'b0; spi_mosi = 1'b0; spi_cs_n = 1'b1;
    loc_adr = '0; loc_we = 1'b0; loc_dat_i = '0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_miso",  spi_miso,  1'b0);
    check("rst_dat_o", loc_dat_o, 8'h00);
    check("rst_wr_evt", wr_evt,   1'b0);
    check("rst_wr_adr", wr_adr,   6'h00);
    check("rst_busy",  busy,      1'b0);
    reset = 1'b0;

    loc_read(6'h37, d);
    check("id_local_rd", d, 8'h92);
    loc_read(6'h09, d);
    check("rst_reg09", d, 8'h00);

    // SPI write 0xA5 to 0x09
    e0 = evt_cnt;
    spi_begin();
    check("busy_in_xfer", busy, 1'b1);
    spi_bits(8'h12, 8, r0);
    spi_bits(8'hA5, 8, r1);
    spi_end();
    check("wr_evt_cnt", evt_cnt - e0, 1);
    check("wr_adr_09", wr_adr, 6'h09);
    check("busy_after", busy, 1'b0);
    loc_read(6'h09, d);
    check("reg09_A5", d, 8'hA5);

    // SPI read of a locally written register
    loc_write(6'h0A, 8'h3C);
    e0 = evt_cnt;
    spi_xfer2(8'h94, 8'h00, r0, r1);
    check("rd_addr_byte", r0, 8'h00);
    check("rd_data_3C", r1, 8'h3C);
    check("rd_no_evt", evt_cnt - e0, 0);

    // ID register over SPI, and writes to it from both sides
    spi_xfer2(8'hEE, 8'h00, r0, r1);
    check("id_spi_rd", r1, 8'h92);
    e0 = evt_cnt;
    spi_xfer2(8'h6E, 8'hFF, r0, r1);
    check("id_wr_no_evt", evt_cnt - e0, 0);
    loc_write(6'h37, 8'h55);
    loc_read(6'h37, d);
    check("id_unchanged", d, 8'h92);

    // Abort mid data byte
    e0 = evt_cnt;
    spi_begin();
    spi_bits(8'h12, 8, r0);
    spi_bits(8'hFF, 4, r1);
    #40;
    spi_cs_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("abort_busy", busy, 1'b0);
    #80;
    check("abort_no_evt", evt_cnt - e0, 0);
    loc_read(6'h09, d);
    check("abort_reg09", d, 8'hA5);
    spi_xfer2(8'h12, 8'h5A, r0, r1);
    check("after_abort_evt", evt_cnt - e0, 1);
    loc_read(6'h09, d);
    check("after_abort_reg", d, 8'h5A);

    // Collision: local write held on 0x05 through the SPI commit cycle
    seen = 1'b0;
    spi_begin();
    spi_bits(8'h0A, 8, r0);
    fork
      spi_bits(8'h22, 8, r1);
      begin
        loc_adr = 6'h05; loc_dat_i = 8'h11; loc_we = 1'b1;
        for (int k = 0; k < 200; k++) begin
          @(negedge clk);
          if (wr_evt) begin
            seen = 1'b1;
            break;
          end
        end
        loc_we = 1'b0;
      end
    join
    spi_end();
    check("coll_evt_seen", seen, 1'b1);
    loc_read(6'h05, d);
    check("coll_spi_wins", d, 8'h22);

    // Two data bytes starting at 0x3F
    e0 = evt_cnt;
    spi_begin();
    spi_bits(8'h7E, 8, r0);
    spi_bits(8'h01, 8, r1);
    spi_bits(8'h02, 8, r1);
    spi_end();
    loc_read(6'h3F, d);
    check("burst_reg3F", d, 8'h01);
`ifdef SPI_SLV_BURST_EN
    loc_read(6'h00, d);
    check("burst_reg00", d, 8'h02);
    check("burst_evts", evt_cnt - e0, 2);
    check("burst_wr_adr", wr_adr, 6'h00);
`else
    loc_read(6'h00, d);
    check("single_reg00", d, 8'h00);
    check("single_evts", evt_cnt - e0, 1);
    check("single_wr_adr", wr_adr, 6'h3F);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
